// File: rtl/stream_demux.sv
// stream_demux: 1-to-N valid/ready stream demultiplexer.
// The channel is chosen by `sig` on the first beat of a packet and held until
// `in_last`. Packets addressed past the last channel are swallowed and counted.
module stream_demux #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 4,
    parameter int SEL_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [SEL_W-1:0]         sig,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_last,
    output logic [N_CH-1:0]          out_valid,
    input  logic [N_CH-1:0]          out_ready,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic [N_CH-1:0]          out_last,
    output logic                     busy,
    output logic                     err,
    output logic [7:0]               drop_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        DROP   = 2'd2
    } state_e;

    // One extra bit so N_CH == 2**SEL_W is representable in the compare.
    localparam logic [SEL_W:0] CH_LIM = (SEL_W+1)'(N_CH);

    state_e                  state_q, state_d;
    logic [SEL_W-1:0]        lock_ch_q, lock_ch_d;
    logic [N_CH-1:0]         out_valid_q, out_valid_d;
    logic [N_CH*DATA_W-1:0]  out_data_q, out_data_d;
    logic [N_CH-1:0]         out_last_q, out_last_d;
    logic                    err_q, err_d;
    logic [7:0]              drop_cnt_q, drop_cnt_d;

    logic                    sig_ok;
    logic [SEL_W-1:0]        target;
    logic                    tgt_ready;
    logic                    accept;
    logic                    route;

    // Handshake, per-channel output register updates and next-state logic.
    always_comb begin
        sig_ok    = ({1'b0, sig} < CH_LIM);
        target    = (state_q == LOCKED) ? lock_ch_q : sig;

        // A channel accepts when empty or draining this cycle (pass-through).
        tgt_ready = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (target == SEL_W'(k)) begin
                tgt_ready = !out_valid_q[k] | out_ready[k];
            end
        end

        case (state_q)
            IDLE:    in_ready = enable & (sig_ok ? tgt_ready : 1'b1);
            LOCKED:  in_ready = enable & tgt_ready;
            default: in_ready = enable;
        endcase

        accept = in_valid & in_ready;
        route  = accept & (((state_q == IDLE) & sig_ok) | (state_q == LOCKED));

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        for (int k = 0; k < N_CH; k++) begin
            if (route && (target == SEL_W'(k))) begin
                out_valid_d[k]                = 1'b1;
                out_data_d[k*DATA_W +: DATA_W] = in_data;
                out_last_d[k]                 = in_last;
            end else if (out_ready[k]) begin
                out_valid_d[k] = 1'b0;
            end
        end

        state_d    = state_q;
        lock_ch_d  = lock_ch_q;
        err_d      = 1'b0;
        drop_cnt_d = drop_cnt_q;

        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (sig_ok) begin
                        if (!in_last) begin
                            lock_ch_d = sig;
                            state_d   = LOCKED;
                        end
                    end else begin
                        err_d = 1'b1;
                        if (drop_cnt_q != 8'hFF) begin
                            drop_cnt_d = drop_cnt_q + 8'd1;
                        end
                        if (!in_last) begin
                            state_d = DROP;
                        end
                    end
                end
                LOCKED: if (in_last) state_d = IDLE;
                DROP:   if (in_last) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State, output registers and status counters with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lock_ch_q   <= '0;
            out_valid_q <= '0;
            out_data_q  <= '0;
            out_last_q  <= '0;
            err_q       <= 1'b0;
            drop_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: a 4-channel instance driven from a vector
// table, a 3-channel instance for invalid-select and drop-count behaviour.
module tb_stream_demux;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 4-channel instance
    logic        en, sg_v, iv, il, ir;
    logic [1:0]  sg;
    logic [7:0]  id;
    logic [3:0]  ordy, ov, ol;
    logic [31:0] od;
    logic        busy, err;
    logic [7:0]  drop;

    // 3-channel instance
    logic        en3, iv3, il3, ir3;
    logic [1:0]  sg3;
    logic [7:0]  id3;
    logic [2:0]  ordy3, ov3, ol3;
    logic [23:0] od3;
    logic        busy3, err3;
    logic [7:0]  drop3;

    stream_demux #(.DATA_W(8), .N_CH(4), .SEL_W(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .enable(en), .sig(sg), .in_valid(iv),
        .in_ready(ir), .in_data(id), .in_last(il), .out_valid(ov),
        .out_ready(ordy), .out_data(od), .out_last(ol), .busy(busy),
        .err(err), .drop_cnt(drop)
    );

    stream_demux #(.DATA_W(8), .N_CH(3), .SEL_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .enable(en3), .sig(sg3), .in_valid(iv3),
        .in_ready(ir3), .in_data(id3), .in_last(il3), .out_valid(ov3),
        .out_ready(ordy3), .out_data(od3), .out_last(ol3), .busy(busy3),
        .err(err3), .drop_cnt(drop3)
    );

    typedef struct packed {
        logic        en;
        logic [1:0]  sg;
        logic        vl;
        logic [7:0]  dt;
        logic        ls;
        logic [3:0]  rdy;
        logic        x_ir;
        logic [3:0]  x_ov;
        logic [31:0] x_od;
        logic [3:0]  x_ol;
        logic        x_busy;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl [NV];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic vec_t mk(input logic e, input logic [1:0] s, input logic v,
                                input logic [7:0] d, input logic l, input logic [3:0] r,
                                input logic xir, input logic [3:0] xov,
                                input logic [31:0] xod, input logic [3:0] xol,
                                input logic xb);
        vec_t t;
        t.en = e; t.sg = s; t.vl = v; t.dt = d; t.ls = l; t.rdy = r;
        t.x_ir = xir; t.x_ov = xov; t.x_od = xod; t.x_ol = xol; t.x_busy = xb;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // routing
        tbl[0]  = mk(1'b1, 2'd0, 1'b1, 8'hA0, 1'b1, 4'hF, 1'b1, 4'b0001, 32'h000000A0, 4'b0001, 1'b0);
        tbl[1]  = mk(1'b1, 2'd1, 1'b1, 8'hA1, 1'b1, 4'hF, 1'b1, 4'b0010, 32'h0000A1A0, 4'b0011, 1'b0);
        tbl[2]  = mk(1'b1, 2'd2, 1'b1, 8'hA2, 1'b1, 4'hF, 1'b1, 4'b0100, 32'h00A2A1A0, 4'b0111, 1'b0);
        tbl[3]  = mk(1'b1, 2'd3, 1'b1, 8'hA3, 1'b1, 4'hF, 1'b1, 4'b1000, 32'hA3A2A1A0, 4'b1111, 1'b0);
        // packet lock on channel 2, sig moves to 1 mid-packet
        tbl[4]  = mk(1'b1, 2'd2, 1'b1, 8'hB0, 1'b0, 4'hF, 1'b1, 4'b0100, 32'hA3B0A1A0, 4'b1011, 1'b1);
        tbl[5]  = mk(1'b1, 2'd1, 1'b1, 8'hB1, 1'b0, 4'hF, 1'b1, 4'b0100, 32'hA3B1A1A0, 4'b1011, 1'b1);
        tbl[6]  = mk(1'b1, 2'd1, 1'b1, 8'hB2, 1'b1, 4'hF, 1'b1, 4'b0100, 32'hA3B2A1A0, 4'b1111, 1'b0);
        tbl[7]  = mk(1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 4'hF, 1'b1, 4'b0000, 32'hA3B2A1A0, 4'b1111, 1'b0);
        // back-pressure on channel 1, then channel 0 flows while 1 is stalled
        tbl[8]  = mk(1'b1, 2'd1, 1'b1, 8'hC0, 1'b0, 4'hD, 1'b1, 4'b0010, 32'hA3B2C0A0, 4'b1101, 1'b1);
        tbl[9]  = mk(1'b1, 2'd1, 1'b1, 8'hC1, 1'b1, 4'hD, 1'b0, 4'b0010, 32'hA3B2C0A0, 4'b1101, 1'b1);
        tbl[10] = mk(1'b1, 2'd1, 1'b1, 8'hC1, 1'b1, 4'hF, 1'b1, 4'b0010, 32'hA3B2C1A0, 4'b1111, 1'b0);
        tbl[11] = mk(1'b1, 2'd0, 1'b1, 8'hD0, 1'b1, 4'hD, 1'b1, 4'b0011, 32'hA3B2C1D0, 4'b1111, 1'b0);
        tbl[12] = mk(1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 4'hF, 1'b1, 4'b0000, 32'hA3B2C1D0, 4'b1111, 1'b0);
        // enable stall for 5 cycles inside a channel-3 packet
        tbl[13] = mk(1'b1, 2'd3, 1'b1, 8'hE0, 1'b0, 4'hF, 1'b1, 4'b1000, 32'hE0B2C1D0, 4'b0111, 1'b1);
        tbl[14] = mk(1'b0, 2'd0, 1'b1, 8'hE1, 1'b0, 4'hF, 1'b0, 4'b0000, 32'hE0B2C1D0, 4'b0111, 1'b1);
        tbl[15] = mk(1'b0, 2'd1, 1'b1, 8'hE1, 1'b0, 4'hF, 1'b0, 4'b0000, 32'hE0B2C1D0, 4'b0111, 1'b1);
        tbl[16] = mk(1'b0, 2'd2, 1'b1, 8'hE1, 1'b0, 4'hF, 1'b0, 4'b0000, 32'hE0B2C1D0, 4'b0111, 1'b1);
        tbl[17] = mk(1'b0, 2'd0, 1'b1, 8'hE1, 1'b0, 4'hF, 1'b0, 4'b0000, 32'hE0B2C1D0, 4'b0111, 1'b1);
        tbl[18] = mk(1'b0, 2'd1, 1'b1, 8'hE1, 1'b0, 4'hF, 1'b0, 4'b0000, 32'hE0B2C1D0, 4'b0111, 1'b1);
        tbl[19] = mk(1'b1, 2'd0, 1'b1, 8'hE1, 1'b0, 4'hF, 1'b1, 4'b1000, 32'hE1B2C1D0, 4'b0111, 1'b1);
        tbl[20] = mk(1'b1, 2'd1, 1'b1, 8'hE2, 1'b1, 4'hF, 1'b1, 4'b1000, 32'hE2B2C1D0, 4'b1111, 1'b0);

        rst_n = 1'b0;
        en = 1'b0; sg = 2'd0; iv = 1'b0; id = 8'h00; il = 1'b0; ordy = 4'hF;
        en3 = 1'b0; sg3 = 2'd0; iv3 = 1'b0; id3 = 8'h00; il3 = 1'b0; ordy3 = 3'b111;
        tick();
        tick();

        // reset state
        chk("rst_ov", 32'(ov), 32'h0);
        chk("rst_od", od, 32'h0);
        chk("rst_ol", 32'(ol), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_drop", 32'(drop), 32'h0);
        chk("rst3_ov", 32'(ov3), 32'h0);
        chk("rst3_drop", 32'(drop3), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            en = tbl[i].en; sg = tbl[i].sg; iv = tbl[i].vl;
            id = tbl[i].dt; il = tbl[i].ls; ordy = tbl[i].rdy;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(ir), 32'(tbl[i].x_ir));
            tick();
            chk($sformatf("v%0d_out_valid", i), 32'(ov), 32'(tbl[i].x_ov));
            chk($sformatf("v%0d_out_data", i), od, tbl[i].x_od);
            chk($sformatf("v%0d_out_last", i), 32'(ol), 32'(tbl[i].x_ol));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].x_busy));
            chk($sformatf("v%0d_err", i), 32'(err), 32'h0);
        end
        chk("drop_valid_only", 32'(drop), 32'h0);

        // reset in the middle of a locked packet
        en = 1'b1; sg = 2'd2; iv = 1'b1; id = 8'hF0; il = 1'b0; ordy = 4'hF;
        tick();
        chk("mid_busy", 32'(busy), 32'h1);
        chk("mid_ov", 32'(ov), 32'b0100);
        rst_n = 1'b0; iv = 1'b0;
        tick();
        chk("mrst_ov", 32'(ov), 32'h0);
        chk("mrst_od", od, 32'h0);
        chk("mrst_ol", 32'(ol), 32'h0);
        chk("mrst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        sg = 2'd1; iv = 1'b1; id = 8'hF1; il = 1'b1;
        #1;
        chk("mrst_in_ready", 32'(ir), 32'h1);
        tick();
        chk("post_ov", 32'(ov), 32'b0010);
        chk("post_od", od, 32'h0000F100);
        chk("post_ol", 32'(ol), 32'b0010);
        chk("post_busy", 32'(busy), 32'h0);
        iv = 1'b0;

        // invalid select on the 3-channel instance: 2-beat packet to sig=3
        en3 = 1'b1; sg3 = 2'd3; iv3 = 1'b1; id3 = 8'hC0; il3 = 1'b0; ordy3 = 3'b111;
        #1;
        chk("inv_in_ready1", 32'(ir3), 32'h1);
        tick();
        chk("inv_ov1", 32'(ov3), 32'h0);
        chk("inv_err1", 32'(err3), 32'h1);
        chk("inv_drop1", 32'(drop3), 32'h1);
        chk("inv_busy1", 32'(busy3), 32'h1);
        sg3 = 2'd0; id3 = 8'hC1; il3 = 1'b1;
        #1;
        chk("inv_in_ready2", 32'(ir3), 32'h1);
        tick();
        chk("inv_ov2", 32'(ov3), 32'h0);
        chk("inv_err2", 32'(err3), 32'h0);
        chk("inv_drop2", 32'(drop3), 32'h1);
        chk("inv_busy2", 32'(busy3), 32'h0);
        sg3 = 2'd0; id3 = 8'hC2; il3 = 1'b1;
        tick();
        chk("after_ov", 32'(ov3), 32'b001);
        chk("after_od", 32'(od3), 32'h0000C2);
        chk("after_ol", 32'(ol3), 32'b001);
        chk("after_err", 32'(err3), 32'h0);

        // drop counter saturation with single-beat invalid packets
        sg3 = 2'd3; id3 = 8'h55; il3 = 1'b1;
        for (int i = 0; i < 253; i++) tick();
        chk("sat_254", 32'(drop3), 32'd254);
        chk("sat_busy", 32'(busy3), 32'h0);
        tick();
        chk("sat_255", 32'(drop3), 32'd255);
        tick();
        chk("sat_hold", 32'(drop3), 32'd255);
        chk("sat_err", 32'(err3), 32'h1);
        iv3 = 1'b0;
        tick();
        chk("sat_err_clr", 32'(err3), 32'h0);
        chk("sat_hold2", 32'(drop3), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
